instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle fetch/execute controller for the 9-bit core (opcode = ir[8:6]: 000 ADD, 001 SUB,
//  010 AND, 011 XOR, 100 LDR, 101 STR, 110 BR, 111 BRZ). Owns the PC and the instruction register.
//  Sequences instruction fetch, ALU write-back, data-memory handshakes and branches.
//  Raises done at program end. Sits between instruction ROM, register file/ALU and data memory.
// PARAMETERS
//  PC_W      8    PC / branch-target width
//  PROG_LEN  256  program ends when the next PC >= PROG_LEN (compare at PC_W+1 bits)
//  MEM_TMO   15   max MEM_WAIT cycles before abort; counter width = $clog2(MEM_TMO+1)
//  CNT_W     16   retired-instruction counter width
// PORTS
//  clk            in   1      clock; all state changes on posedge
//  reset          in   1      synchronous, active-high
//  start          in   1      launch program from PC 0; sampled only in IDLE/DONE
//  instr          in   9      instruction ROM data for pc (combinational ROM)
//  zero_flag      in   1      ALU zero flag, used by BRZ
//  branch_target  in   PC_W   target PC for BR/BRZ, valid during EXEC
//  dmem_ready     in   1      data memory completes the request this cycle
//  pc             out  PC_W   current PC
//  ir             out  9      latched instruction
//  imem_en        out  1      instruction fetch strobe
//  alu_op         out  3      = ir[8:6] for ADD..XOR, else 000
//  rf_we          out  1      register-file write strobe, 1 cycle
//  dmem_req       out  1      data-memory request, level
//  dmem_we        out  1      1 = store (STR), qualifies dmem_req
//  done           out  1      program finished (level)
//  mem_err        out  1      memory timeout abort (sticky until next start)
//  retired        out  CNT_W  retired instructions, saturating
// BEHAVIOUR
//  Reset: state=IDLE; pc=0, ir=0, retired=0, mem timeout counter=0; all strobes, done and mem_err=0.
//  Reset mid-operation: same values on the same edge; dmem_req drops immediately.
//  States: IDLE, FETCH, EXEC, MEM_WAIT, DONE.
//  IDLE/DONE + start: pc<=0, retired<=0, done<=0, mem_err<=0, go to FETCH. start in other states: ignored.
//  FETCH: imem_en=1; ir<=instr at end of cycle; go to EXEC.
//  EXEC, ALU ops: alu_op=ir[8:6], rf_we=1 for this cycle, pc<=pc+1.
//  EXEC, BR: pc<=branch_target.
//  EXEC, BRZ: pc<=zero_flag ? branch_target : pc+1.
//  EXEC, LDR/STR: dmem_req=1 (dmem_we=1 for STR); timeout counter<=0; go to MEM_WAIT. pc unchanged.
//  MEM_WAIT: dmem_req/dmem_we held stable until dmem_ready is seen.
//   On dmem_ready: rf_we=1 that cycle if LDR; pc<=pc+1.
//   No ready for MEM_TMO cycles: mem_err<=1, done<=1, go to DONE; pc not advanced, not retired.
//  Retire point: EXEC for ALU/branch ops, dmem_ready cycle for LDR/STR. retired+1 per retire, saturates.
//  After a retire: if next PC >= PROG_LEN, done<=1 and go to DONE; else go to FETCH.
//   A branch target >= PROG_LEN also ends the program.
//  pc+1 is computed at PC_W+1 bits. Overflow past 2^PC_W-1 ends the program; the stored pc wraps to 0.
//  Latency: ALU/BR/BRZ take 2 cycles; LDR/STR take 3 + wait cycles (dmem_ready on the first MEM_WAIT cycle = 3).
//  dmem_ready outside MEM_WAIT is ignored.
//  Outputs: all strobes are combinational from state+ir, glitch-free at the clock edge.
//   pc, ir, done, mem_err and retired are registered.
// TESTING
//  1 Reset then start; ROM = ADD,SUB,AND,XOR, PROG_LEN=4 -> rf_we pulses in cycles 2,4,6,8;
//    alu_op = 000,001,010,011; done=1 after cycle 8; retired=4.
//  2 LDR with dmem_ready 3 cycles after the request -> dmem_req high exactly 3 cycles, rf_we once
//    on the ready cycle, pc 0->1.
//  3 BRZ at pc=5, target=2: zero_flag=1 -> pc=2; zero_flag=0 -> pc=6. BR at pc=7, target=200 with
//    PROG_LEN=10 -> done.
//  4 STR with dmem_ready never asserted, MEM_TMO=15 -> mem_err=1, done=1 after 15 wait cycles,
//    retired unchanged, dmem_req drops.
//  5 reset asserted during MEM_WAIT -> next cycle dmem_req=0, pc=0, state IDLE.
//    start pulsed mid-run -> no effect.
//  6 PROG_LEN=256, PC_W=8, ADD at pc=255 -> done=1, pc=0, retired incremented.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/execute controller for the 9-bit core.
// Owns PC and IR, sequences fetch, ALU write-back, data-memory handshakes and
// branches, and flags program end or memory-timeout abort.
module instr_sequencer #(
  parameter int PC_W     = 8,
  parameter int PROG_LEN = 256,
  parameter int MEM_TMO  = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [8:0]       instr,
  input  logic             zero_flag,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             dmem_ready,
  output logic [PC_W-1:0]  pc,
  output logic [8:0]       ir,
  output logic             imem_en,
  output logic [2:0]       alu_op,
  output logic             rf_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             done,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);

  localparam int TMO_W = $clog2(MEM_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TMO - 1);
  localparam logic [PC_W:0]    PROG_END = (PC_W + 1)'(PROG_LEN);

  localparam logic [2:0] OP_LDR = 3'b100;
  localparam logic [2:0] OP_STR = 3'b101;
  localparam logic [2:0] OP_BR  = 3'b110;
  localparam logic [2:0] OP_BRZ = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_EXEC     = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [8:0]        ir_q;
  logic [CNT_W-1:0]  retired_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              done_q;
  logic              mem_err_q;

  logic [2:0]        opcode_s;
  logic              is_mem_s;
  logic              is_alu_s;
  logic [PC_W:0]     pc_inc_s;
  logic [PC_W:0]     npc_d;
  logic              end_s;
  logic              retire_s;

  assign opcode_s = ir_q[8:6];
  assign is_mem_s = (opcode_s == OP_LDR) || (opcode_s == OP_STR);
  assign is_alu_s = (opcode_s[2] == 1'b0);
  // One extra bit so that stepping past the last PC is visible as program end.
  assign pc_inc_s = {1'b0, pc_q} + {{PC_W{1'b0}}, 1'b1};
  assign end_s    = (npc_d >= PROG_END);

  // Next PC after the current instruction retires (branches pick the target).
  always_comb begin
    npc_d = pc_inc_s;
    case (opcode_s)
      OP_BR:   npc_d = {1'b0, branch_target};
      OP_BRZ:  npc_d = zero_flag ? {1'b0, branch_target} : pc_inc_s;
      default: npc_d = pc_inc_s;
    endcase
  end

  // Retire point: EXEC for non-memory ops, the ready cycle for LDR/STR.
  always_comb begin
    retire_s = 1'b0;
    if (state_q == S_EXEC) begin
      retire_s = !is_mem_s;
    end else if (state_q == S_MEM_WAIT) begin
      retire_s = dmem_ready;
    end else begin
      retire_s = 1'b0;
    end
  end

  // Strobes decoded from state and IR only (plus ready for the LDR write-back).
  always_comb begin
    imem_en  = 1'b0;
    alu_op   = 3'b000;
    rf_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    case (state_q)
      S_FETCH: imem_en = 1'b1;
      S_EXEC: begin
        if (is_alu_s) begin
          alu_op = opcode_s;
          rf_we  = 1'b1;
        end else if (is_mem_s) begin
          dmem_req = 1'b1;
          dmem_we  = (opcode_s == OP_STR);
        end else begin
          alu_op = 3'b000;
        end
      end
      S_MEM_WAIT: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode_s == OP_STR);
        rf_we    = dmem_ready && (opcode_s == OP_LDR);
      end
      default: imem_en = 1'b0;
    endcase
  end

  // Sequencer FSM with PC, IR, retire counter, timeout and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= {PC_W{1'b0}};
      ir_q      <= 9'd0;
      retired_q <= {CNT_W{1'b0}};
      tmo_q     <= {TMO_W{1'b0}};
      done_q    <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc_q      <= {PC_W{1'b0}};
            retired_q <= {CNT_W{1'b0}};
            done_q    <= 1'b0;
            mem_err_q <= 1'b0;
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir_q    <= instr;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (is_mem_s) begin
            tmo_q   <= {TMO_W{1'b0}};
            state_q <= S_MEM_WAIT;
          end else begin
            state_q <= end_s ? S_DONE : S_FETCH;
          end
        end
        S_MEM_WAIT: begin
          if (dmem_ready) begin
            state_q <= end_s ? S_DONE : S_FETCH;
          end else if (tmo_q == TMO_LAST) begin
            mem_err_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (retire_s) begin
        pc_q   <= npc_d[PC_W-1:0];
        done_q <= end_s;
        if (retired_q != {CNT_W{1'b1}}) begin
          retired_q <= retired_q + CNT_W'(1);
        end
      end
    end
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign done    = done_q;
  assign mem_err = mem_err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: three instances with program lengths
// 4, 10 and 256 share a behavioural ROM; register-file write strobes are
// matched against an expected-event scoreboard.
module tb_instr_sequencer;
  localparam int PC_W  = 8;
  localparam int CNT_W = 16;
  localparam int N     = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             zero_flag;
  logic             dmem_ready;
  logic [PC_W-1:0]  branch_target;
  logic [N-1:0]     start;
  logic [8:0]       rom [256];
  logic [8:0]       instr [N];
  logic [PC_W-1:0]  pc [N];
  logic [8:0]       ir [N];
  logic [2:0]       alu_op [N];
  logic [CNT_W-1:0] retired [N];
  logic [N-1:0]     imem_en, rf_we, dmem_req, dmem_we, done, mem_err;

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign instr[g] = rom[pc[g]];
    instr_sequencer #(
      .PC_W(PC_W), .PROG_LEN(g == 0 ? 4 : (g == 1 ? 10 : 256)),
      .MEM_TMO(15), .CNT_W(CNT_W)
    ) u_dut (
      .clk(clk), .reset(reset), .start(start[g]), .instr(instr[g]),
      .zero_flag(zero_flag), .branch_target(branch_target),
      .dmem_ready(dmem_ready), .pc(pc[g]), .ir(ir[g]), .imem_en(imem_en[g]),
      .alu_op(alu_op[g]), .rf_we(rf_we[g]), .dmem_req(dmem_req[g]),
      .dmem_we(dmem_we[g]), .done(done[g]), .mem_err(mem_err[g]),
      .retired(retired[g])
    );
  end

  typedef struct { int cyc; logic [2:0] op; } exp_t;
  exp_t exp_q[$];

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int sel = 0;
  int cyc_no = 0;
  int req_cnt = 0;
  int we_cnt = 0;

  localparam logic [8:0] I_ADD = 9'b000_001_010;
  localparam logic [8:0] I_SUB = 9'b001_011_100;
  localparam logic [8:0] I_AND = 9'b010_101_110;
  localparam logic [8:0] I_XOR = 9'b011_111_000;
  localparam logic [8:0] I_LDR = 9'b100_001_000;
  localparam logic [8:0] I_STR = 9'b101_010_000;
  localparam logic [8:0] I_BR  = 9'b110_000_000;
  localparam logic [8:0] I_BRZ = 9'b111_000_000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample strobes mid-cycle, then cross the edge.
  task automatic cyc(input logic rdy, input logic zf);
    exp_t e;
    dmem_ready = rdy;
    zero_flag  = zf;
    #1;
    if (rf_we[sel] === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rf_we_extra", 32'(rf_we[sel]), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rf_we_cycle", 32'(cyc_no), 32'(e.cyc));
        chk("alu_op", 32'(alu_op[sel]), 32'(e.op));
      end
    end
    if (dmem_req[sel] === 1'b1) req_cnt++;
    if (dmem_we[sel] === 1'b1) we_cnt++;
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic launch(input int s);
    sel = s;
    start[s] = 1'b1;
    cyc(1'b0, 1'b0);
    start[s] = 1'b0;
    cyc_no = 1;
    req_cnt = 0;
    we_cnt = 0;
  endtask

  task automatic run_instr(input logic [PC_W-1:0] tgt, input logic zf);
    branch_target = tgt;
    cyc(1'b0, 1'b0);
    cyc(1'b0, zf);
  endtask

  initial begin
    reset = 1'b0;
    start = '0;
    zero_flag = 1'b0;
    dmem_ready = 1'b0;
    branch_target = '0;
    for (int i = 0; i < 256; i++) rom[i] = I_ADD;

    // Reset state
    do_reset();
    cyc(1'b0, 1'b0);
    chk("rst_pc", 32'(pc[0]), 32'd0);
    chk("rst_ir", 32'(ir[0]), 32'd0);
    chk("rst_retired", 32'(retired[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    chk("rst_mem_err", 32'(mem_err[0]), 32'd0);
    chk("rst_strobes", 32'({imem_en[0], rf_we[0], dmem_req[0], dmem_we[0]}), 32'd0);

    // ALU program, PROG_LEN=4; a start pulse mid-run must be ignored
    rom[0] = I_ADD; rom[1] = I_SUB; rom[2] = I_AND; rom[3] = I_XOR;
    exp_q.push_back('{2, 3'b000});
    exp_q.push_back('{4, 3'b001});
    exp_q.push_back('{6, 3'b010});
    exp_q.push_back('{8, 3'b011});
    launch(0);
    chk("fetch_imem_en", 32'(imem_en[0]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      start[0] = (i == 4);
      cyc(1'b0, 1'b0);
    end
    start[0] = 1'b0;
    chk("alu_done", 32'(done[0]), 32'd1);
    chk("alu_retired", 32'(retired[0]), 32'd4);
    chk("alu_pc", 32'(pc[0]), 32'd4);
    chk("alu_q_empty", 32'(exp_q.size()), 32'd0);

    // LDR with ready on the second MEM_WAIT cycle; early ready ignored
    do_reset();
    rom[0] = I_LDR;
    launch(1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    exp_q.push_back('{4, 3'b000});
    cyc(1'b1, 1'b0);
    chk("ldr_req_cycles", 32'(req_cnt), 32'd3);
    chk("ldr_we_cycles", 32'(we_cnt), 32'd0);
    chk("ldr_pc", 32'(pc[1]), 32'd1);
    chk("ldr_retired", 32'(retired[1]), 32'd1);
    chk("ldr_req_drop", 32'(dmem_req[1]), 32'd0);
    chk("ldr_q_empty", 32'(exp_q.size()), 32'd0);

    // Branches, PROG_LEN=10
    do_reset();
    rom[0] = I_BR; rom[5] = I_BRZ; rom[2] = I_BR; rom[6] = I_BR; rom[7] = I_BR;
    launch(1);
    run_instr(8'd5, 1'b0);
    chk("br_pc5", 32'(pc[1]), 32'd5);
    run_instr(8'd2, 1'b1);
    chk("brz_taken", 32'(pc[1]), 32'd2);
    run_instr(8'd5, 1'b0);
    run_instr(8'd2, 1'b0);
    chk("brz_not_taken", 32'(pc[1]), 32'd6);
    run_instr(8'd7, 1'b0);
    chk("br_done_early", 32'(done[1]), 32'd0);
    run_instr(8'd200, 1'b0);
    chk("br_far_done", 32'(done[1]), 32'd1);
    chk("br_far_pc", 32'(pc[1]), 32'd200);
    chk("br_retired", 32'(retired[1]), 32'd6);

    // STR timeout
    do_reset();
    rom[0] = I_STR;
    launch(1);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0);
    chk("tmo_not_yet", 32'(done[1]), 32'd0);
    chk("tmo_req_held", 32'(dmem_req[1]), 32'd1);
    cyc(1'b0, 1'b0);
    chk("tmo_mem_err", 32'(mem_err[1]), 32'd1);
    chk("tmo_done", 32'(done[1]), 32'd1);
    chk("tmo_retired", 32'(retired[1]), 32'd0);
    chk("tmo_pc", 32'(pc[1]), 32'd0);
    chk("tmo_req_drop", 32'(dmem_req[1]), 32'd0);
    chk("tmo_req_cycles", 32'(req_cnt), 32'd16);
    chk("tmo_we_cycles", 32'(we_cnt), 32'd16);

    // Restart from DONE clears mem_err; reset during MEM_WAIT
    rom[0] = I_LDR;
    launch(1);
    chk("restart_mem_err", 32'(mem_err[1]), 32'd0);
    chk("restart_done", 32'(done[1]), 32'd0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("mw_req", 32'(dmem_req[1]), 32'd1);
    do_reset();
    chk("mw_rst_req", 32'(dmem_req[1]), 32'd0);
    chk("mw_rst_pc", 32'(pc[1]), 32'd0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("mw_rst_idle", 32'({imem_en[1], dmem_req[1], done[1]}), 32'd0);

    // PC overflow, PROG_LEN=256
    rom[0] = I_BR; rom[255] = I_ADD;
    launch(2);
    run_instr(8'd255, 1'b0);
    chk("ovf_pc255", 32'(pc[2]), 32'd255);
    exp_q.push_back('{4, 3'b000});
    run_instr(8'd0, 1'b0);
    chk("ovf_done", 32'(done[2]), 32'd1);
    chk("ovf_pc_wrap", 32'(pc[2]), 32'd0);
    chk("ovf_retired", 32'(retired[2]), 32'd2);
    chk("ovf_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
